// File: rtl/write_back_stage.sv
// Write-back stage: source muxes feed a 2-entry elastic buffer toward the register file.
// Push in cycle N is visible at the head in N+1; head holds while out_ready is low; in_ready drops when full.
module write_back_stage #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     Imm970,
  input  logic [DATA_W-1:0]     MemData,
  input  logic [DATA_W-1:0]     PCImmInc,
  input  logic [DATA_W-1:0]     ALUOut,
  input  logic [DATA_W-1:0]     PCInc,
  input  logic [1:0]            regSelect,
  input  logic [2:0]            r7Select,
  input  logic [REG_ADDR_W-1:0] regAddr,
  input  logic                  regWrEn,
  input  logic                  r7WrEn,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     writeData,
  output logic [REG_ADDR_W-1:0] writeAddr,
  output logic [DATA_W-1:0]     writeR7Data,
  output logic                  regWrite,
  output logic                  r7Write,
  output logic                  fwdValid,
  output logic [REG_ADDR_W-1:0] fwdAddr,
  output logic [DATA_W-1:0]     fwdData,
  output logic [CNT_W-1:0]      retiredCount
);

  localparam logic [REG_ADDR_W-1:0] R7_ADDR = {REG_ADDR_W{1'b1}};

  typedef struct packed {
    logic [DATA_W-1:0]     wr_data;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0]     r7_data;
    logic                  reg_wr_en;
    logic                  r7_wr_en;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state, state_nxt;
  entry_t head, second, new_entry;
  logic   push, pop;
  logic   load_head_new, load_head_second, load_second;
  logic [DATA_W-1:0] reg_mux, r7_mux;

  always_comb begin
    reg_mux = '0;
    case (regSelect)
      2'd0:    reg_mux = MemData;
      2'd1:    reg_mux = ALUOut;
      2'd2:    reg_mux = Imm970;
      default: reg_mux = PCInc;
    endcase
  end

  always_comb begin
    r7_mux = '0;
    case (r7Select)
      3'd0:    r7_mux = Imm970;
      3'd1:    r7_mux = MemData;
      3'd2:    r7_mux = PCImmInc;
      3'd3:    r7_mux = ALUOut;
      3'd4:    r7_mux = PCInc;
      default: r7_mux = '0;
    endcase
  end

  // A simultaneous R7 port write and a regular write to R7 resolve in favour of the R7 port.
  always_comb begin
    new_entry.wr_data   = reg_mux;
    new_entry.wr_addr   = regAddr;
    new_entry.r7_data   = r7_mux;
    new_entry.r7_wr_en  = r7WrEn;
    new_entry.reg_wr_en = regWrEn & ~(r7WrEn & (regAddr == R7_ADDR));
  end

  assign push      = in_valid & in_ready;
  assign out_valid = (state != EMPTY);
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    load_head_new    = 1'b0;
    load_head_second = 1'b0;
    load_second      = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          state_nxt     = ONE;
          load_head_new = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          load_head_new = 1'b1;
        end else if (push) begin
          state_nxt   = TWO;
          load_second = 1'b1;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_nxt        = ONE;
          load_head_second = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) in_ready <= 1'b1;
    else        in_ready <= (state_nxt != TWO);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head   <= '0;
      second <= '0;
    end else begin
      if (load_head_new)         head <= new_entry;
      else if (load_head_second) head <= second;
      if (load_second)           second <= new_entry;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   retiredCount <= '0;
    else if (pop) retiredCount <= retiredCount + 1'b1;
  end

  assign writeData   = head.wr_data;
  assign writeAddr   = head.wr_addr;
  assign writeR7Data = head.r7_data;
  assign regWrite    = pop & head.reg_wr_en;
  assign r7Write     = pop & head.r7_wr_en;
  assign fwdValid    = out_valid & head.reg_wr_en;
  assign fwdAddr     = head.wr_addr;
  assign fwdData     = head.wr_data;

endmodule

// File: tb/tb_write_back_stage.sv
// Scoreboard bench for write_back_stage: driver queues expected head entries, monitor checks each pop.
module tb_write_back_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [15:0] Imm970, MemData, PCImmInc, ALUOut, PCInc;
  logic [1:0]  regSelect;
  logic [2:0]  r7Select, regAddr;
  logic        regWrEn, r7WrEn, out_ready, out_valid;
  logic [15:0] writeData, writeR7Data, fwdData;
  logic [2:0]  writeAddr, fwdAddr;
  logic        regWrite, r7Write, fwdValid;
  logic [15:0] retiredCount;

  typedef struct {
    logic [15:0] wd;
    logic [2:0]  wa;
    logic [15:0] r7d;
    logic        rw;
    logic        r7w;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   model_pops = 0;

  write_back_stage #(.DATA_W(16), .REG_ADDR_W(3), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .Imm970(Imm970), .MemData(MemData), .PCImmInc(PCImmInc), .ALUOut(ALUOut), .PCInc(PCInc),
    .regSelect(regSelect), .r7Select(r7Select), .regAddr(regAddr), .regWrEn(regWrEn),
    .r7WrEn(r7WrEn), .out_ready(out_ready), .out_valid(out_valid), .writeData(writeData),
    .writeAddr(writeAddr), .writeR7Data(writeR7Data), .regWrite(regWrite), .r7Write(r7Write),
    .fwdValid(fwdValid), .fwdAddr(fwdAddr), .fwdData(fwdData), .retiredCount(retiredCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every pop is compared against the oldest queued expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got out_valid 1 expected empty scoreboard");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("writeData",    writeData,         e.wd);
        check("writeAddr",    {13'd0, writeAddr}, {13'd0, e.wa});
        check("writeR7Data",  writeR7Data,       e.r7d);
        check("regWrite",     {15'd0, regWrite}, {15'd0, e.rw});
        check("r7Write",      {15'd0, r7Write},  {15'd0, e.r7w});
        check("fwdValid",     {15'd0, fwdValid}, {15'd0, e.rw});
        check("fwdAddr",      {13'd0, fwdAddr},  {13'd0, e.wa});
        check("fwdData",      fwdData,           e.wd);
        check("retiredCount", retiredCount,      model_pops[15:0]);
        model_pops++;
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push(input logic [1:0] rs, input logic [2:0] r7s, input logic [2:0] ra,
                      input logic rwe, input logic r7we,
                      input logic [15:0] ewd, input logic [15:0] er7d, input logic erw);
    exp_t e;
    bit   done = 0;
    regSelect = rs; r7Select = r7s; regAddr = ra; regWrEn = rwe; r7WrEn = r7we;
    in_valid = 1'b1;
    e.wd = ewd; e.wa = ra; e.r7d = er7d; e.rw = erw; e.r7w = r7we;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        @(posedge clk); #1;
        done = 1;
      end
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got in_ready 0 expected 1 within 20 cycles");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", 16'(exp_q.size()), 16'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"},    {15'd0, out_valid}, 16'd0);
    check({tag, "_in_ready"},     {15'd0, in_ready},  16'd1);
    check({tag, "_retiredCount"}, retiredCount,       16'd0);
    check({tag, "_writeData"},    writeData,          16'd0);
    check({tag, "_writeR7Data"},  writeR7Data,        16'd0);
    check({tag, "_writeAddr"},    {13'd0, writeAddr}, 16'd0);
    check({tag, "_fwdValid"},     {15'd0, fwdValid},  16'd0);
    check({tag, "_regWrite"},     {15'd0, regWrite},  16'd0);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    Imm970 = 16'h0055; MemData = 16'hFFFF; PCImmInc = 16'h0ABC; ALUOut = 16'h1234; PCInc = 16'h0101;
    regSelect = 2'd0; r7Select = 3'd0; regAddr = 3'd0; regWrEn = 1'b0; r7WrEn = 1'b0;
    #12;
    check_reset_state("reset");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // ALU result to R3, head visible one cycle after push
    push(2'd1, 3'd0, 3'd3, 1'b1, 1'b0, 16'h1234, 16'h0055, 1'b1);
    check("t1_out_valid", {15'd0, out_valid}, 16'd1);
    check("t1_writeData", writeData, 16'h1234);
    drain();
    check("t1_retired", retiredCount, 16'd1);

    // r7Select 5..7 yields zero regardless of sources
    push(2'd0, 3'd5, 3'd2, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b0);
    push(2'd0, 3'd6, 3'd2, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b0);
    push(2'd0, 3'd7, 3'd2, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b0);
    push(2'd2, 3'd2, 3'd1, 1'b1, 1'b1, 16'h0055, 16'h0ABC, 1'b1);
    push(2'd3, 3'd4, 3'd0, 1'b1, 1'b0, 16'h0101, 16'h0101, 1'b1);
    push(2'd0, 3'd1, 3'd4, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
    push(2'd1, 3'd3, 3'd5, 1'b1, 1'b0, 16'h1234, 16'h1234, 1'b1);
    drain();

    // Backpressure: two entries fill the buffer, head held
    out_ready = 1'b0;
    ALUOut = 16'hAAAA;
    push(2'd1, 3'd0, 3'd1, 1'b1, 1'b0, 16'hAAAA, 16'h0055, 1'b1);
    ALUOut = 16'hBBBB;
    push(2'd1, 3'd0, 3'd2, 1'b1, 1'b0, 16'hBBBB, 16'h0055, 1'b1);
    ALUOut = 16'hCCCC;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_in_ready",  {15'd0, in_ready}, 16'd0);
      check("t3_hold_data", writeData, 16'hAAAA);
      check("t3_regWrite",  {15'd0, regWrite}, 16'd0);
      check("t3_fwdValid",  {15'd0, fwdValid}, 16'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // Push and pop in the same cycle while holding one entry
    out_ready = 1'b0;
    ALUOut = 16'h0A0A;
    push(2'd1, 3'd0, 3'd3, 1'b1, 1'b0, 16'h0A0A, 16'h0055, 1'b1);
    out_ready = 1'b1;
    ALUOut = 16'h0C0C;
    push(2'd1, 3'd0, 3'd4, 1'b1, 1'b0, 16'h0C0C, 16'h0055, 1'b1);
    check("t4_out_valid", {15'd0, out_valid}, 16'd1);
    check("t4_head_c",    writeData, 16'h0C0C);
    check("t4_in_ready",  {15'd0, in_ready}, 16'd1);
    drain();

    // Regular write to R7 loses to the R7 port
    ALUOut = 16'h7777;
    push(2'd1, 3'd3, 3'd7, 1'b1, 1'b1, 16'h7777, 16'h7777, 1'b0);
    drain();
    check("retired_total", retiredCount, 16'd13);

    // Asynchronous reset with two entries held
    out_ready = 1'b0;
    push(2'd1, 3'd0, 3'd1, 1'b1, 1'b0, 16'h7777, 16'h0055, 1'b1);
    push(2'd1, 3'd0, 3'd2, 1'b1, 1'b0, 16'h7777, 16'h0055, 1'b1);
    check("t6_full", {15'd0, in_ready}, 16'd0);
    #2;
    reset = 1'b0;
    #1;
    check_reset_state("async_reset");
    exp_q.delete();
    model_pops = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    out_ready = 1'b1;
    ALUOut = 16'h4321;
    push(2'd1, 3'd0, 3'd6, 1'b1, 1'b0, 16'h4321, 16'h0055, 1'b1);
    drain();
    check("post_reset_retired", retiredCount, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
